// File: rtl/lpi_sram_responder_if.sv
// lpi_sram_responder_if: LPI request (slxq*) and reply (slxy*) channel bundle
interface lpi_sram_responder_if #(
  parameter int BW_AXI_ADDR   = 32,
  parameter int BW_AXI_DATA   = 32,
  parameter int BW_LPI_BURDEN = 1,
  parameter int BW_AXI_ALEN   = 8,
  parameter int BW_AXI_ASIZE  = 3,
  parameter int BW_AXI_ABURST = 2,
  parameter int BW_AXI_RESP   = 2
);
  logic [1:0]                 slxqdready;
  logic                       slxqvalid;
  logic                       slxqlast;
  logic                       slxqwrite;
  logic [BW_AXI_ALEN-1:0]     slxqlen;
  logic [BW_AXI_ASIZE-1:0]    slxqsize;
  logic [BW_AXI_ABURST-1:0]   slxqburst;
  logic [BW_AXI_DATA/8-1:0]   slxqwstrb;
  logic [BW_AXI_DATA-1:0]     slxqwdata;
  logic [BW_AXI_ADDR-1:0]     slxqaddr;
  logic [BW_LPI_BURDEN-1:0]   slxqburden;
  logic [1:0]                 slxydready;
  logic                       slxyvalid;
  logic                       slxylast;
  logic                       slxywreply;
  logic [BW_AXI_RESP-1:0]     slxyresp;
  logic [BW_AXI_DATA-1:0]     slxyrdata;
  logic [BW_LPI_BURDEN-1:0]   slxyburden;
  modport master (
    input  slxqdready, slxyvalid, slxylast, slxywreply, slxyresp, slxyrdata, slxyburden,
    output slxqvalid, slxqlast, slxqwrite, slxqlen, slxqsize, slxqburst, slxqwstrb,
           slxqwdata, slxqaddr, slxqburden, slxydready
  );
  modport slave (
    output slxqdready, slxyvalid, slxylast, slxywreply, slxyresp, slxyrdata, slxyburden,
    input  slxqvalid, slxqlast, slxqwrite, slxqlen, slxqsize, slxqburst, slxqwstrb,
           slxqwdata, slxqaddr, slxqburden, slxydready
  );
endinterface

// File: rtl/lpi_sram_responder.sv
// lpi_sram_responder: LPI memory-side responder over a byte-strobed SRAM.
// Define LPI_SRAM_RESPONDER_ADDR_CHECK_EN to flag beats beyond the SRAM with DECERR.
module lpi_sram_responder #(
  parameter int BW_AXI_ADDR   = 32,
  parameter int BW_AXI_DATA   = 32,
  parameter int BW_LPI_BURDEN = 1,
  parameter int DEPTH_LOG2    = 10,
  parameter int BW_AXI_ALEN   = 8,
  parameter int BW_AXI_ASIZE  = 3,
  parameter int BW_AXI_ABURST = 2,
  parameter int BW_AXI_RESP   = 2
) (
  input logic clk,
  input logic rst,
  lpi_sram_responder_if.slave s
);
  localparam int NB = BW_AXI_DATA / 8;
  localparam int LB = $clog2(NB);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef logic [BW_AXI_ADDR-1:0] addr_t;
  typedef logic [BW_AXI_ALEN-1:0] len_t;
  typedef logic [BW_AXI_ASIZE-1:0] size_t;
  typedef logic [BW_AXI_ABURST-1:0] burst_t;
  typedef logic [BW_AXI_RESP-1:0] resp_t;
  typedef logic [BW_AXI_DATA-1:0] data_t;
  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;
  localparam resp_t SLVERR = resp_t'(2);
  localparam resp_t DECERR = resp_t'(3);
  data_t mem [DEPTH];
  state_t state_q, state_d;
  logic [1:0] dready_q, dready_d;
  addr_t addr_q, addr_d;
  len_t len_q, len_d, cnt_q, cnt_d;
  size_t size_q, size_d;
  burst_t burst_q, burst_d;
  logic [BW_LPI_BURDEN-1:0] burden_q, burden_d;
  resp_t err_q, err_d;
  logic issued_q, issued_d;
  logic p_valid_q, p_valid_d, p_last_q, p_last_d;
  resp_t p_resp_q, p_resp_d;
  data_t p_data_q, p_rdata;
  logic yvalid_q, yvalid_d, ylast_q, ylast_d, ywreply_q, ywreply_d;
  resp_t yresp_q, yresp_d;
  data_t ydata_q, ydata_d;
  logic s_valid_q, s_valid_d, s_last_q, s_last_d;
  resp_t s_resp_q, s_resp_d;
  data_t s_data_q, s_data_d;
  logic idle, wfire, rfire, pop, wpop, issue, xerr, dec, mism, we;
  addr_t c_addr, a_next;
  len_t c_len;
  size_t c_size;
  burst_t c_burst;
  resp_t beat_resp, wresp;
  logic [1:0] occ;
  logic [DEPTH_LOG2-1:0] idx;
  function automatic addr_t nxt(addr_t a, size_t sz, len_t ln, burst_t bu);
    addr_t inc, m;
    inc = a + (addr_t'(1) << sz);
    m = ((addr_t'(ln) + addr_t'(1)) << sz) - addr_t'(1);
    return bu == burst_t'(0) ? a : bu == burst_t'(2) ? (a & ~m) | (inc & m) : inc;
  endfunction
  function automatic resp_t worst(resp_t a, resp_t b);
    return a > b ? a : b;
  endfunction
  assign idle = state_q == IDLE;
  assign wfire = s.slxqvalid & s.slxqwrite & dready_q[1];
  assign rfire = s.slxqvalid & ~s.slxqwrite & dready_q[0];
  // In IDLE the first beat is served straight from the request fields
  assign c_addr = idle ? s.slxqaddr : addr_q;
  assign c_len = idle ? s.slxqlen : len_q;
  assign c_size = idle ? s.slxqsize : size_q;
  assign c_burst = idle ? s.slxqburst : burst_q;
  assign xerr = (c_size > size_t'(LB)) |
                ((c_burst == burst_t'(2)) & !(c_len inside {len_t'(1), len_t'(3), len_t'(7), len_t'(15)}));
`ifdef LPI_SRAM_RESPONDER_ADDR_CHECK_EN
  assign dec = c_addr >= addr_t'(DEPTH * NB);
`else
  assign dec = 1'b0;
`endif
  assign beat_resp = dec ? DECERR : xerr ? SLVERR : '0;
  assign mism = s.slxqlast != ((idle ? len_t'(0) : cnt_q) == c_len);
  assign wresp = worst(worst(idle ? '0 : err_q, beat_resp), mism ? SLVERR : '0);
  assign we = wfire & ~dec & ~xerr & ~rst;
  assign a_next = nxt(c_addr, c_size, c_len, c_burst);
  assign idx = c_addr[DEPTH_LOG2+LB-1:LB];
  assign pop = yvalid_q & ~ywreply_q & s.slxydready[0];
  assign wpop = yvalid_q & ywreply_q & s.slxydready[1];
  // Head register, skid entry and SRAM read stage together never exceed two beats
  assign occ = 2'(yvalid_q) + 2'(s_valid_q) + 2'(p_valid_q);
  assign issue = (state_q == RDATA) & ~issued_q & ((occ - 2'(pop)) < 2'd2);
  assign p_rdata = p_resp_q == '0 ? p_data_q : '0;
  assign s.slxqdready = dready_q;
  assign s.slxyvalid = yvalid_q;
  assign s.slxylast = ylast_q;
  assign s.slxywreply = ywreply_q;
  assign s.slxyresp = yresp_q;
  assign s.slxyrdata = ydata_q;
  assign s.slxyburden = burden_q;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    len_d = len_q;
    size_d = size_q;
    burst_d = burst_q;
    burden_d = burden_q;
    cnt_d = cnt_q;
    err_d = err_q;
    issued_d = issued_q;
    p_valid_d = issue;
    p_last_d = cnt_q == len_q;
    p_resp_d = beat_resp;
    yvalid_d = yvalid_q;
    ylast_d = ylast_q;
    ywreply_d = ywreply_q;
    yresp_d = yresp_q;
    ydata_d = ydata_q;
    s_last_d = p_valid_q ? p_last_q : s_last_q;
    s_resp_d = p_valid_q ? p_resp_q : s_resp_q;
    s_data_d = p_valid_q ? p_rdata : s_data_q;
    s_valid_d = (!yvalid_q || pop) ? s_valid_q & p_valid_q : s_valid_q | p_valid_q;
    if (issue) begin
      addr_d = a_next;
      cnt_d = cnt_q + len_t'(1);
      issued_d = cnt_q == len_q;
    end
    if (!yvalid_q || pop) begin
      yvalid_d = s_valid_q | p_valid_q;
      ywreply_d = 1'b0;
      ylast_d = s_valid_q ? s_last_q : p_last_q;
      yresp_d = s_valid_q ? s_resp_q : p_resp_q;
      ydata_d = s_valid_q ? s_data_q : p_rdata;
    end
    if (idle && (wfire || rfire)) begin
      len_d = s.slxqlen;
      size_d = s.slxqsize;
      burst_d = s.slxqburst;
      burden_d = s.slxqburden;
      addr_d = s.slxqaddr;
      cnt_d = '0;
      issued_d = 1'b0;
      state_d = RDATA;
    end
    if (wfire) begin
      addr_d = a_next;
      cnt_d = (idle ? len_t'(0) : cnt_q) + len_t'(1);
      err_d = wresp;
      state_d = s.slxqlast ? WRESP : WDATA;
      if (s.slxqlast) begin
        yvalid_d = 1'b1;
        ywreply_d = 1'b1;
        ylast_d = 1'b1;
        yresp_d = wresp;
        ydata_d = '0;
      end
    end
    if (wpop) begin
      yvalid_d = 1'b0;
      ywreply_d = 1'b0;
      state_d = IDLE;
    end
    if (pop && ylast_q) state_d = IDLE;
    dready_d = state_d == IDLE ? 2'b11 : state_d == WDATA ? 2'b10 : 2'b00;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dready_q <= 2'b00;
      addr_q <= '0;
      len_q <= '0;
      size_q <= '0;
      burst_q <= '0;
      burden_q <= '0;
      cnt_q <= '0;
      err_q <= '0;
      issued_q <= 1'b0;
      p_valid_q <= 1'b0;
      p_last_q <= 1'b0;
      p_resp_q <= '0;
      yvalid_q <= 1'b0;
      ylast_q <= 1'b0;
      ywreply_q <= 1'b0;
      yresp_q <= '0;
      ydata_q <= '0;
      s_valid_q <= 1'b0;
      s_last_q <= 1'b0;
      s_resp_q <= '0;
      s_data_q <= '0;
    end else begin
      state_q <= state_d;
      dready_q <= dready_d;
      addr_q <= addr_d;
      len_q <= len_d;
      size_q <= size_d;
      burst_q <= burst_d;
      burden_q <= burden_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      issued_q <= issued_d;
      p_valid_q <= p_valid_d;
      p_last_q <= p_last_d;
      p_resp_q <= p_resp_d;
      yvalid_q <= yvalid_d;
      ylast_q <= ylast_d;
      ywreply_q <= ywreply_d;
      yresp_q <= yresp_d;
      ydata_q <= ydata_d;
      s_valid_q <= s_valid_d;
      s_last_q <= s_last_d;
      s_resp_q <= s_resp_d;
      s_data_q <= s_data_d;
    end
  end
  always_ff @(posedge clk) begin
    if (we)
      for (int b = 0; b < NB; b++)
        if (s.slxqwstrb[b]) mem[idx][8*b +: 8] <= s.slxqwdata[8*b +: 8];
    if (issue) p_data_q <= mem[idx];
  end
endmodule

// File: tb/tb_lpi_sram_responder.sv
// tb_lpi_sram_responder: directed and randomized checks of lpi_sram_responder against a word-array memory model
module tb_lpi_sram_responder;
  localparam int DL = 10;
  localparam int DEPTH = 1 << DL;
`ifdef LPI_SRAM_RESPONDER_ADDR_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  lpi_sram_responder_if bus ();
  lpi_sram_responder #(.DEPTH_LOG2(DL)) dut (.clk(clk), .rst(rst), .s(bus));
  int checks = 0;
  int errors = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] wd [256];
  logic [3:0] ws [256];
  logic tag;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] baddr(logic [31:0] a, int len, int size, int burst, int i);
    int unsigned nb, wsz;
    logic [31:0] base;
    nb = 1 << size;
    wsz = (len + 1) * nb;
    if (burst == 0) return a;
    if (burst != 2) return a + i * nb;
    base = a - a % wsz;
    return base + (a - base + i * nb) % wsz;
  endfunction

  function automatic bit xerr(int len, int size, int burst);
    return size > 2 || (burst == 2 && !(len inside {1, 3, 7, 15}));
  endfunction

  function automatic bit dec(logic [31:0] a);
    return CHECK && a >= DEPTH * 4;
  endfunction

  function automatic int widx(logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  task automatic do_write(input logic [31:0] a, input int len, input int size, input int burst, input int nb);
    int worst, e, n;
    logic [31:0] ba;
    worst = 0;
    tag = 1'($urandom);
    for (int i = 0; i < nb; i++) begin
      ba = baddr(a, len, size, burst, i);
      e = dec(ba) ? 3 : xerr(len, size, burst) ? 2 : 0;
      if (((i == nb - 1) != (i == len)) && e < 2) e = 2;
      if (e > worst) worst = e;
      if (!dec(ba) && !xerr(len, size, burst))
        for (int b = 0; b < 4; b++) if (ws[i][b]) ref_mem[widx(ba)][8*b +: 8] = wd[i][8*b +: 8];
      @(negedge clk);
      bus.slxqvalid = 1'b1;
      bus.slxqwrite = 1'b1;
      bus.slxqlast = (i == nb - 1);
      bus.slxqlen = 8'(len);
      bus.slxqsize = 3'(size);
      bus.slxqburst = 2'(burst);
      bus.slxqaddr = a;
      bus.slxqwdata = wd[i];
      bus.slxqwstrb = ws[i];
      bus.slxqburden = tag;
      n = 0;
      while (!bus.slxqdready[1] && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("wr_accept", 64'(bus.slxqdready[1]), 64'd1);
    end
    @(negedge clk);
    bus.slxqvalid = 1'b0;
    chk("wr_reply", {bus.slxyvalid, bus.slxywreply, bus.slxylast, bus.slxyresp, bus.slxyrdata, bus.slxyburden},
        {3'b111, 2'(worst), 32'h0, tag});
    @(negedge clk);
    chk("wr_done", {bus.slxyvalid, bus.slxqdready}, 3'b011);
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0, 2: random ready
  task automatic do_read(input logic [31:0] a, input int len, input int size, input int burst, input int mode);
    int k, lat, first, lastlat, n, e;
    logic r;
    logic [31:0] ba, ed;
    k = 0; lat = 0; first = -1; lastlat = 0; n = 0;
    tag = 1'($urandom);
    @(negedge clk);
    bus.slxqvalid = 1'b1;
    bus.slxqwrite = 1'b0;
    bus.slxqlast = 1'b1;
    bus.slxqlen = 8'(len);
    bus.slxqsize = 3'(size);
    bus.slxqburst = 2'(burst);
    bus.slxqaddr = a;
    bus.slxqburden = tag;
    while (!bus.slxqdready[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rd_accept", 64'(bus.slxqdready[0]), 64'd1);
    @(negedge clk);
    bus.slxqvalid = 1'b0;
    while (k <= len && lat < 2000) begin
      r = mode == 0 ? 1'b1 : mode == 1 ? (lat % 3 == 0) : 1'($urandom);
      if (bus.slxyvalid) begin
        ba = baddr(a, len, size, burst, k);
        e = dec(ba) ? 3 : xerr(len, size, burst) ? 2 : 0;
        ed = e == 0 ? ref_mem[widx(ba)] : 32'h0;
        if (first < 0) first = lat;
        chk("rd_beat", {bus.slxywreply, bus.slxylast, bus.slxyresp, bus.slxyrdata, bus.slxyburden},
            {1'b0, k == len, 2'(e), ed, tag});
        if (r) begin
          lastlat = lat;
          k++;
        end
      end
      bus.slxydready[0] = r;
      @(negedge clk);
      lat++;
    end
    chk("rd_complete", 64'(k), 64'(len + 1));
    if (mode == 0) begin
      chk("rd_latency", 64'(first), 64'd2);
      chk("rd_throughput", 64'(lastlat - first), 64'(len));
    end
    chk("rd_done", {bus.slxyvalid, bus.slxqdready}, 3'b011);
    bus.slxydready[0] = 1'b1;
  endtask

  initial begin
    int n;
    bus.slxqvalid = 1'b0;
    bus.slxqlast = 1'b0;
    bus.slxqwrite = 1'b0;
    bus.slxqlen = '0;
    bus.slxqsize = '0;
    bus.slxqburst = '0;
    bus.slxqwstrb = '0;
    bus.slxqwdata = '0;
    bus.slxqaddr = '0;
    bus.slxqburden = '0;
    bus.slxydready = 2'b11;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", {bus.slxqdready, bus.slxyvalid, bus.slxylast, bus.slxywreply, bus.slxyresp,
                        bus.slxyrdata, bus.slxyburden}, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_release", 64'(bus.slxqdready), 64'd3);
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 256; i++) begin
        wd[i] = $urandom;
        ws[i] = 4'hF;
      end
      do_write(32'(blk * 1024), 255, 2, 1, 256);
    end
    for (int i = 0; i < 4; i++) begin
      wd[i] = 32'hA0 + 32'(i);
      ws[i] = 4'hF;
    end
    do_write(32'h100, 3, 2, 1, 4);
    do_read(32'h100, 3, 2, 1, 0);
    do_read(32'h100, 3, 2, 1, 1);
    wd[0] = 32'hFFFF_FFFF;
    ws[0] = 4'hF;
    do_write(32'h200, 0, 2, 1, 1);
    wd[0] = 32'h1122_3344;
    ws[0] = 4'h5;
    do_write(32'h200, 0, 2, 1, 1);
    do_read(32'h200, 0, 2, 1, 0);
    do_read(32'h200, 2, 2, 0, 0);
    do_read(32'h1000, 0, 2, 1, 0);
    do_read(32'h100, 1, 3, 1, 0);
    do_write(32'h300, 1, 3, 1, 2);
    for (int i = 0; i < 4; i++) begin
      wd[i] = $urandom;
      ws[i] = 4'hF;
    end
    do_write(32'h30C, 3, 2, 2, 4);
    do_read(32'h30C, 3, 2, 2, 2);
    do_write(32'h340, 2, 2, 2, 3);
    do_read(32'h340, 2, 2, 2, 0);
    do_write(32'h380, 3, 2, 1, 2);
    do_write(32'h3A0, 1, 2, 1, 3);
    do_read(32'h380, 11, 2, 1, 2);
    for (int i = 0; i < 4; i++) ws[i] = 4'($urandom);
    do_write(32'h3C1, 3, 0, 1, 4);
    do_read(32'h3C1, 3, 0, 1, 0);
    @(negedge clk);
    bus.slxqvalid = 1'b1;
    bus.slxqwrite = 1'b0;
    bus.slxqlast = 1'b1;
    bus.slxqlen = 8'd7;
    bus.slxqsize = 3'd2;
    bus.slxqburst = 2'd1;
    bus.slxqaddr = 32'h100;
    chk("rst_rd_accept", 64'(bus.slxqdready[0]), 64'd1);
    @(negedge clk);
    bus.slxqvalid = 1'b0;
    n = 0;
    while (!bus.slxyvalid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rst_rd_first", 64'(bus.slxyvalid), 64'd1);
    @(negedge clk);
    chk("rst_rd_beat1", {bus.slxyvalid, bus.slxyrdata}, {1'b1, ref_mem[widx(32'h104)]});
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid", {bus.slxyvalid, bus.slxqdready}, 3'b000);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_after", {bus.slxyvalid, bus.slxqdready}, 3'b011);
    do_read(32'h100, 7, 2, 1, 0);
    for (int t = 0; t < 25; t++) begin
      int rl, rs, rb;
      logic [31:0] ra;
      rb = int'($urandom_range(0, 2));
      rs = $urandom_range(0, 9) == 0 ? 3 : int'($urandom_range(0, 2));
      rl = rb == 2 ? (2 << $urandom_range(0, 3)) - 1 : int'($urandom_range(0, 15));
      ra = $urandom_range(0, 4095);
      for (int i = 0; i <= rl; i++) begin
        wd[i] = $urandom;
        ws[i] = 4'($urandom);
      end
      do_write(ra, rl, rs, rb, rl + 1);
      do_read(ra, rl, rs, rb, 2);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
